// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: walks an MxNxK GEMM as TILE-sized (m,n,k) tiles and issues one command per tile
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           one-cycle launch; config inputs are latched on it
//   matrix_m/n/k, data_format       GEMM dimensions and A/B element format
//   accumulate_mode                 1 = add onto existing C
//   addr_a/b/c_base                 operand base byte addresses
//   cmd_*                           tile command (valid/ready handshake)
//   tile_done                       one pulse per completed command
//   busy, done, cycles_counter      job status back to the config block
module gemm_tile_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int TILE            = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           matrix_m,
    input  logic [15:0]           matrix_n,
    input  logic [15:0]           matrix_k,
    input  logic [1:0]            data_format,
    input  logic                  accumulate_mode,
    input  logic [ADDR_WIDTH-1:0] addr_a_base,
    input  logic [ADDR_WIDTH-1:0] addr_b_base,
    input  logic [ADDR_WIDTH-1:0] addr_c_base,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr_a,
    output logic [ADDR_WIDTH-1:0] cmd_addr_b,
    output logic [ADDR_WIDTH-1:0] cmd_addr_c,
    output logic [7:0]            cmd_rows,
    output logic [7:0]            cmd_cols,
    output logic [7:0]            cmd_depth,
    output logic                  cmd_acc_init,
    output logic                  cmd_last_k,
    input  logic                  tile_done,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           cycles_counter
);
    localparam int TSH = $clog2(TILE);
    localparam logic [15:0] T16 = 16'(TILE);
    localparam logic [ADDR_WIDTH-1:0] TA = ADDR_WIDTH'(TILE);
    localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [15:0] m_r, n_r, k_r, mt, nt, kt, tmt, tnt, tkt, rm, rn, rk;
    logic [1:0] esh;
    logic acc_r, hs, dec, lm, ln, lk, load, launch;
    logic [ADDR_WIDTH-1:0] a_r, b_r, c_r;
    logic [3:0] outstanding;

    // Last-tile flags come from the remaining extent rather than tile counts;
    // t*t are the indices of the command to load next (all zero in SETUP).
    always_comb begin
        busy = state != S_IDLE;
        launch = state == S_IDLE && start;
        cmd_valid = state == S_ISSUE && outstanding < MAXO;
        hs = cmd_valid && cmd_ready;
        dec = tile_done && outstanding != 4'd0;
        lm = (m_r - (mt << TSH)) <= T16;
        ln = (n_r - (nt << TSH)) <= T16;
        lk = (k_r - (kt << TSH)) <= T16;
        load = state == S_SETUP || hs;
        tkt = (state == S_SETUP || lk) ? 16'd0 : kt + 16'd1;
        tnt = (state == S_SETUP || (lk && ln)) ? 16'd0 : lk ? nt + 16'd1 : nt;
        tmt = state == S_SETUP ? 16'd0 : (lk && ln) ? mt + 16'd1 : mt;
        rm = m_r - (tmt << TSH);
        rn = n_r - (tnt << TSH);
        rk = k_r - (tkt << TSH);
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_SETUP : S_IDLE;
            S_SETUP: state_nx = (m_r == 16'd0 || n_r == 16'd0 || k_r == 16'd0) ? S_DONE : S_ISSUE;
            S_ISSUE: state_nx = (hs && lk && ln && lm) ? S_DRAIN : S_ISSUE;
            S_DRAIN: state_nx = outstanding == 4'd0 ? S_DONE : S_DRAIN;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            {m_r, n_r, k_r, mt, nt, kt} <= '0;
            {esh, acc_r, a_r, b_r, c_r} <= '0;
            outstanding <= '0;
            done <= 1'b0;
            cycles_counter <= '0;
            {cmd_addr_a, cmd_addr_b, cmd_addr_c} <= '0;
            {cmd_rows, cmd_cols, cmd_depth, cmd_acc_init, cmd_last_k} <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                {m_r, n_r, k_r} <= {matrix_m, matrix_n, matrix_k};
                esh <= data_format == 2'b00 ? 2'd0 : data_format == 2'b11 ? 2'd2 : 2'd1;
                acc_r <= accumulate_mode;
                {a_r, b_r, c_r} <= {addr_a_base, addr_b_base, addr_c_base};
            end
            if (load) begin
                {mt, nt, kt} <= {tmt, tnt, tkt};
                cmd_addr_a <= a_r + ((ADDR_WIDTH'(tmt) * TA * ADDR_WIDTH'(k_r) + ADDR_WIDTH'(tkt) * TA) << esh);
                cmd_addr_b <= b_r + ((ADDR_WIDTH'(tkt) * TA * ADDR_WIDTH'(n_r) + ADDR_WIDTH'(tnt) * TA) << esh);
                cmd_addr_c <= c_r + ((ADDR_WIDTH'(tmt) * TA * ADDR_WIDTH'(n_r) + ADDR_WIDTH'(tnt) * TA) << 2);
                cmd_rows <= rm > T16 ? 8'(TILE) : rm[7:0];
                cmd_cols <= rn > T16 ? 8'(TILE) : rn[7:0];
                cmd_depth <= rk > T16 ? 8'(TILE) : rk[7:0];
                cmd_acc_init <= tkt == 16'd0 && !acc_r;
                cmd_last_k <= rk <= T16;
            end
            if (hs && !dec)
                outstanding <= outstanding + 4'd1;
            else if (dec && !hs)
                outstanding <= outstanding - 4'd1;
            if (launch)
                done <= 1'b0;
            else if (state == S_DONE)
                done <= 1'b1;
            if (launch)
                cycles_counter <= '0;
            else if (busy && cycles_counter != '1)
                cycles_counter <= cycles_counter + 32'd1;
        end
    end
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// tb_gemm_tile_scheduler: directed bench for gemm_tile_scheduler
module tb_gemm_tile_scheduler;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] matrix_m = '0, matrix_n = '0, matrix_k = '0;
    logic [1:0] data_format = '0;
    logic accumulate_mode = 1'b0, cmd_ready = 1'b0, tile_done = 1'b0;
    logic [31:0] addr_a_base = '0, addr_b_base = '0, addr_c_base = '0;
    logic cmd_valid, cmd_acc_init, cmd_last_k, busy, done;
    logic [31:0] cmd_addr_a, cmd_addr_b, cmd_addr_c, cycles_counter;
    logic [7:0] cmd_rows, cmd_cols, cmd_depth;

    typedef struct packed {
        logic [31:0] a, b, c;
        logic [7:0] rows, cols, depth;
        logic acc, lk;
    } cmd_t;

    cmd_t cmds[$];
    cmd_t prev, cur;
    int dq[$];
    int cyc = 0, n_cmp = 0, n_err = 0, busy_cnt = 0, nhs = 0, nvalid = 0, lat = 10;
    bit auto_done = 1'b1, rdy_rand = 1'b0, prev_wait = 1'b0;

    gemm_tile_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .matrix_m(matrix_m), .matrix_n(matrix_n), .matrix_k(matrix_k),
        .data_format(data_format), .accumulate_mode(accumulate_mode),
        .addr_a_base(addr_a_base), .addr_b_base(addr_b_base), .addr_c_base(addr_c_base),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_depth(cmd_depth),
        .cmd_acc_init(cmd_acc_init), .cmd_last_k(cmd_last_k),
        .tile_done(tile_done), .busy(busy), .done(done), .cycles_counter(cycles_counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [31:0] a, b, c, input logic [7:0] r, co, d, input logic ai, lk);
        return {a, b, c, r, co, d, ai, lk};
    endfunction

    function automatic cmd_t fields();
        return {cmd_addr_a, cmd_addr_b, cmd_addr_c, cmd_rows, cmd_cols, cmd_depth, cmd_acc_init, cmd_last_k};
    endfunction

    // One clock: drive inputs, sample outputs 2 time units after the previous edge, then advance.
    task automatic step();
        if (rdy_rand) cmd_ready = 1'($urandom_range(0, 1));
        tile_done = 1'b0;
        if (dq.size() != 0 && dq[0] <= cyc) begin
            tile_done = 1'b1;
            void'(dq.pop_front());
        end
        #1;
        cur = fields();
        if (busy) busy_cnt++;
        if (cmd_valid) nvalid++;
        if (prev_wait) begin
            chk("hold_valid", cmd_valid, 1);
            chk("hold_fields", cur, prev);
        end
        prev_wait = cmd_valid && !cmd_ready;
        prev = cur;
        if (cmd_valid && cmd_ready) begin
            cmds.push_back(cur);
            nhs++;
            if (auto_done) begin
                dq.push_back(cyc + lat);
                dq.sort();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i = 0;
        while (!done && i < limit) begin
            step();
            i++;
        end
        chk("wait_done", done, 1);
    endtask

    task automatic cfg(input int m, n, k, input logic [1:0] f, input logic acc, input logic [31:0] a, b, c);
        matrix_m = 16'(m); matrix_n = 16'(n); matrix_k = 16'(k);
        data_format = f; accumulate_mode = acc;
        addr_a_base = a; addr_b_base = b; addr_c_base = c;
        cmds.delete();
        busy_cnt = 0;
        nhs = 0;
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_cycles", cycles_counter, 0);
        chk("rst_fields", fields(), 0);
        rst_n = 1'b1;
        step();

        cfg(16, 16, 16, 2'b00, 1'b0, 32'h1000, 32'h2000, 32'h3000);
        cmd_ready = 1'b1; auto_done = 1'b1; lat = 10;
        do_start();
        chk("t1_busy_lat", busy, 1);
        chk("t1_valid_lat", cmd_valid, 0);
        step();
        chk("t1_valid", cmd_valid, 1);
        wait_done(100);
        chk("t1_ncmd", cmds.size(), 1);
        chk("t1_cmd0", cmds[0], mk(32'h1000, 32'h2000, 32'h3000, 16, 16, 16, 1, 1));
        chk("t1_busy", busy, 0);
        chk("t1_cycles", cycles_counter, busy_cnt);

        cfg(32, 16, 40, 2'b01, 1'b0, 32'h10000, 32'h20000, 32'h30000);
        lat = 2;
        do_start();
        chk("t2_done_clr", done, 0);
        wait_done(200);
        chk("t2_ncmd", cmds.size(), 6);
        chk("t2_cmd2", cmds[2], mk(32'h10000 + 64, 32'h20000 + 1024, 32'h30000, 16, 16, 8, 0, 1));
        chk("t2_cmd3", cmds[3], mk(32'h10000 + 1280, 32'h20000, 32'h30000 + 1024, 16, 16, 16, 1, 0));
        chk("t2_cycles", cycles_counter, busy_cnt);

        begin
            int v0;
            cfg(16, 16, 0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
            v0 = nvalid;
            do_start();
            chk("t3_busy", busy, 1);
            step();
            step();
            chk("t3_done", done, 1);
            chk("t3_busy_low", busy, 0);
            chk("t3_novalid", nvalid - v0, 0);
            chk("t3_cycles", cycles_counter, 2);
        end

        cfg(48, 48, 16, 2'b00, 1'b0, 32'h4000, 32'h5000, 32'h6000);
        auto_done = 1'b0;
        do_start();
        repeat (12) step();
        chk("t4_nhs_max", nhs, 4);
        chk("t4_stall", cmd_valid, 0);
        dq.push_back(cyc);
        step();
        step();
        step();
        chk("t4_nhs_one", nhs, 5);
        chk("t4_stall2", cmd_valid, 0);
        dq.push_back(cyc);
        dq.push_back(cyc + 1);
        step();
        step();
        chk("t4_coinc_valid", cmd_valid, 1);
        step();
        chk("t4_stall3", cmd_valid, 0);
        chk("t4_nhs_coinc", nhs, 7);
        auto_done = 1'b1; lat = 3;
        for (int i = 1; i <= 4; i++) dq.push_back(cyc + i);
        wait_done(300);
        chk("t4_ncmd", cmds.size(), 9);
        chk("t4_cmd4", cmds[4], mk(32'h4000 + 256, 32'h5000 + 16, 32'h6000 + 3136, 16, 16, 16, 1, 1));
        chk("t4_cmd8", cmds[8], mk(32'h4000 + 512, 32'h5000 + 32, 32'h6000 + 6272, 16, 16, 16, 1, 1));

        cfg(16, 16, 48, 2'b11, 1'b1, 32'h100, 32'h200, 32'h300);
        lat = 4;
        do_start();
        step();
        step();
        matrix_m = 16'd64; matrix_k = 16'd16; accumulate_mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_busy_ign", busy, 1);
        wait_done(200);
        chk("t5_ncmd", cmds.size(), 3);
        chk("t5_cmd0", cmds[0], mk(32'h100, 32'h200, 32'h300, 16, 16, 16, 0, 0));
        chk("t5_cmd1_acc", cmds[1].acc, 0);
        chk("t5_cmd2", cmds[2], mk(32'h100 + 128, 32'h200 + 2048, 32'h300, 16, 16, 16, 0, 1));

        cfg(48, 48, 16, 2'b00, 1'b0, 32'h700, 32'h800, 32'h900);
        cmd_ready = 1'b0;
        do_start();
        step();
        chk("t5_pre_rst_valid", cmd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", cmd_valid, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_cycles", cycles_counter, 0);
        chk("t5_rst_fields", fields(), 0);
        prev_wait = 1'b0;
        dq.delete();
        step();
        rst_n = 1'b1;
        step();
        cfg(16, 16, 16, 2'b00, 1'b0, 32'h1000, 32'h2000, 32'h3000);
        cmd_ready = 1'b1; lat = 5;
        do_start();
        wait_done(100);
        chk("t5_post_ncmd", cmds.size(), 1);
        chk("t5_post_cmd0", cmds[0], mk(32'h1000, 32'h2000, 32'h3000, 16, 16, 16, 1, 1));
        chk("t5_post_cycles", cycles_counter, busy_cnt);

        cfg(32, 32, 32, 2'b01, 1'b0, 32'h8000, 32'h9000, 32'hA000);
        rdy_rand = 1'b1; lat = 3;
        do_start();
        wait_done(500);
        rdy_rand = 1'b0;
        cmd_ready = 1'b1;
        chk("t6_ncmd", cmds.size(), 8);
        chk("t6_cmd5", cmds[5], mk(32'h8000 + 1056, 32'h9000 + 1024, 32'hA000 + 2048, 16, 16, 16, 0, 1));
        chk("t6_cmd7", cmds[7], mk(32'h8000 + 1056, 32'h9000 + 1056, 32'hA000 + 2112, 16, 16, 16, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
